// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter stage.
package pc_pkg;

    typedef enum logic {
        PC_RUN  = 1'b0,
        PC_TRAP = 1'b1
    } pc_state_t;

    localparam logic [2:0]  F3_BEQ  = 3'b000;
    localparam logic [2:0]  F3_BNE  = 3'b001;
    localparam logic [2:0]  F3_BLT  = 3'b100;
    localparam logic [2:0]  F3_BGE  = 3'b101;

    localparam logic [63:0] PC_STEP = 64'd4;

    localparam int unsigned STAT_W  = 32;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        return (value == '1) ? value : value + STAT_W'(1);
    endfunction

endpackage

// File: rtl/pc_branch_stats.sv
// Saturating retired-branch and taken-branch counters for the PC stage.
module pc_branch_stats
    import pc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              count_en,
    input  logic              branch,
    input  logic              taken,
    output logic [STAT_W-1:0] branch_count,
    output logic [STAT_W-1:0] taken_count
);

    logic [STAT_W-1:0] branch_q;
    logic [STAT_W-1:0] taken_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            branch_q <= '0;
            taken_q  <= '0;
        end else if (count_en) begin
            if (branch) begin
                branch_q <= sat_inc(branch_q);
            end
            if (taken) begin
                taken_q <= sat_inc(taken_q);
            end
        end
    end

    assign branch_count = branch_q;
    assign taken_count  = taken_q;

endmodule

// File: rtl/pc_next_unit.sv
// Program counter with branch-target selection and misaligned-target trap.
// Optional statistics counters are enabled by defining PC_BRANCH_STATS_EN.
module pc_next_unit
    import pc_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Branch,
    input  logic [2:0]  Funct,
    input  logic        BLT,
    input  logic        BGE,
    input  logic        Zero,
    input  logic [63:0] Imm,
    output logic [63:0] PC,
    output logic [63:0] PCPlus4,
    output logic        Taken,
    output logic        Trap
`ifdef PC_BRANCH_STATS_EN
    ,
    output logic [31:0] BranchCount,
    output logic [31:0] TakenCount
`endif
);

    pc_state_t   state_q;
    pc_state_t   state_d;
    logic [63:0] pc_q;
    logic [63:0] target;
    logic        raw_taken;
    logic        misaligned;
    logic        pc_en;
    logic        running;

    assign raw_taken = Branch & (BLT | BGE
                               | ((Funct == F3_BEQ) &  Zero)
                               | ((Funct == F3_BNE) & ~Zero));

    assign target     = pc_q + (Imm << 1);
    assign PCPlus4    = pc_q + PC_STEP;
    assign misaligned = Taken & (target[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PC_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PC_RUN: begin
                if (!Stall && misaligned) begin
                    state_d = PC_TRAP;
                end
            end
            PC_TRAP: state_d = PC_TRAP;
            default: state_d = PC_RUN;
        endcase
    end

    // Trap blanks Taken so downstream logic never sees a branch while parked.
    always_comb begin
        running = (state_q == PC_RUN);
        Taken   = running & raw_taken;
        Trap    = (state_q == PC_TRAP);
        pc_en   = running & ~Stall & ~misaligned;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (pc_en) begin
            pc_q <= Taken ? target : PCPlus4;
        end
    end

    assign PC = pc_q;

`ifdef PC_BRANCH_STATS_EN
    pc_branch_stats u_stats (
        .clk          (clk),
        .reset        (reset),
        .count_en     (running & ~Stall),
        .branch       (Branch),
        .taken        (Taken & ~misaligned),
        .branch_count (BranchCount),
        .taken_count  (TakenCount)
    );
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit with a cycle-level reference model.
module tb_pc_next_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic        Branch;
    logic [2:0]  Funct;
    logic        BLT;
    logic        BGE;
    logic        Zero;
    logic [63:0] Imm;
    logic [63:0] PC;
    logic [63:0] PCPlus4;
    logic        Taken;
    logic        Trap;
`ifdef PC_BRANCH_STATS_EN
    logic [31:0] BranchCount;
    logic [31:0] TakenCount;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    logic [63:0] m_pc;
    bit          m_trap;
    longint unsigned m_bc;
    longint unsigned m_tc;

    pc_next_unit #(.RESET_PC(64'h0)) dut (
        .clk     (clk),
        .reset   (reset),
        .Stall   (Stall),
        .Branch  (Branch),
        .Funct   (Funct),
        .BLT     (BLT),
        .BGE     (BGE),
        .Zero    (Zero),
        .Imm     (Imm),
        .PC      (PC),
        .PCPlus4 (PCPlus4),
        .Taken   (Taken),
        .Trap    (Trap)
`ifdef PC_BRANCH_STATS_EN
        ,
        .BranchCount (BranchCount),
        .TakenCount  (TakenCount)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: decision rules applied with plain arithmetic.
    function automatic bit model_taken();
        return !m_trap && Branch &&
               (BLT || BGE || (Funct == 3'd0 && Zero) || (Funct == 3'd1 && !Zero));
    endfunction

    always @(posedge clk) begin
        logic [63:0] tgt;
        bit          tk;
        tk  = model_taken();
        tgt = m_pc + Imm * 64'd2;
        if (reset) begin
            m_pc   <= 64'h0;
            m_trap <= 1'b0;
            m_bc   <= 0;
            m_tc   <= 0;
        end else if (!m_trap && !Stall) begin
            if (Branch) m_bc <= m_bc + 1;
            if (tk && (tgt % 4) != 0) begin
                m_trap <= 1'b1;
            end else begin
                if (tk) m_tc <= m_tc + 1;
                m_pc <= tk ? tgt : m_pc + 64'd4;
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("model_pc",      PC,      m_pc);
            check("model_pcplus4", PCPlus4, m_pc + 64'd4);
            check("model_trap",    {63'd0, Trap},  {63'd0, m_trap});
            check("model_taken",   {63'd0, Taken}, {63'd0, model_taken()});
`ifdef PC_BRANCH_STATS_EN
            check("model_bcount",  {32'd0, BranchCount}, m_bc);
            check("model_tcount",  {32'd0, TakenCount},  m_tc);
`endif
        end
    end

    task automatic set_in(input logic r, input logic s, input logic b, input logic [2:0] f,
                          input logic lt, input logic ge, input logic z, input logic [63:0] im);
        reset  = r;
        Stall  = s;
        Branch = b;
        Funct  = f;
        BLT    = lt;
        BGE    = ge;
        Zero   = z;
        Imm    = im;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 64'd0);
    endtask

    // Reset, then step sequentially up to the requested aligned PC.
    task automatic go_pc(input int unsigned target_pc);
        set_in(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        idle();
        for (int unsigned k = 0; k < target_pc / 4; k++) tick();
    endtask

    initial begin
        set_in(1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        tick();
        checking = 1'b1;
        check("reset_pc",   PC, 64'd0);
        check("reset_trap", {63'd0, Trap}, 64'd0);
`ifdef PC_BRANCH_STATS_EN
        check("reset_bcount", {32'd0, BranchCount}, 64'd0);
        check("reset_tcount", {32'd0, TakenCount},  64'd0);
`endif

        idle();
        tick(); check("seq_pc4",  PC, 64'd4);
        tick(); check("seq_pc8",  PC, 64'd8);
        tick(); check("seq_pc12", PC, 64'd12);
        check("seq_trap", {63'd0, Trap}, 64'd0);

        go_pc(8);
        set_in(1'b0, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 64'd8);
        #1 check("blt_taken", {63'd0, Taken}, 64'd1);
        tick(); check("blt_target", PC, 64'd24);

        go_pc(8);
        set_in(1'b0, 1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0, 64'd8);
        #1 check("blt_not_taken", {63'd0, Taken}, 64'd0);
        tick(); check("blt_fall", PC, 64'd12);

        idle();
        tick(); check("to_16", PC, 64'd16);
        set_in(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        tick(); check("beq_back", PC, 64'd8);
        idle();
        tick();
        tick();
        set_in(1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        tick(); check("bne_fall", PC, 64'd20);

        set_in(1'b0, 1'b1, 1'b1, 3'b101, 1'b0, 1'b1, 1'b0, 64'd8);
        for (int i = 0; i < 3; i++) begin
            #1 check("stall_taken", {63'd0, Taken}, 64'd1);
            tick(); check("stall_hold", PC, 64'd20);
`ifdef PC_BRANCH_STATS_EN
            check("stall_bcount", {32'd0, BranchCount}, 64'd3);
            check("stall_tcount", {32'd0, TakenCount},  64'd1);
`endif
        end
        Stall = 1'b0;
        tick(); check("stall_release", PC, 64'd36);
`ifdef PC_BRANCH_STATS_EN
        check("release_bcount", {32'd0, BranchCount}, 64'd4);
        check("release_tcount", {32'd0, TakenCount},  64'd2);
`endif
        idle();
        tick(); check("release_once", PC, 64'd40);

        go_pc(0);
        set_in(1'b0, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
        tick(); check("wrap_target", PC, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_pcplus4", PCPlus4, 64'd0);
        idle();
        tick(); check("wrap_pc", PC, 64'd0);

        go_pc(4);
        set_in(1'b0, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 64'd1);
        #1 check("misalign_taken", {63'd0, Taken}, 64'd1);
        tick();
        check("trap_set", {63'd0, Trap}, 64'd1);
        check("trap_pc",  PC, 64'd4);
        for (int i = 0; i < 5; i++) begin
            set_in(1'b0, 1'(i % 2), 1'b1, 3'b000, 1'b1, 1'b1, 1'b1, 64'd8);
            #1 check("trap_taken_low", {63'd0, Taken}, 64'd0);
            tick();
            check("trap_pc_hold", PC, 64'd4);
            check("trap_stays",   {63'd0, Trap}, 64'd1);
        end
        set_in(1'b1, 1'b1, 1'b1, 3'b000, 1'b1, 1'b1, 1'b1, 64'd8);
        tick();
        check("trap_reset_pc",   PC, 64'd0);
        check("trap_reset_trap", {63'd0, Trap}, 64'd0);

        // Five branches, three taken, the last taken one misaligned.
        set_in(1'b0, 1'b0, 1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 64'd4);
        tick(); check("stats_b1", PC, 64'd8);
        set_in(1'b0, 1'b0, 1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 64'd4);
        tick(); check("stats_b2", PC, 64'd12);
        set_in(1'b0, 1'b0, 1'b1, 3'b101, 1'b0, 1'b1, 1'b0, 64'd2);
        tick(); check("stats_b3", PC, 64'd16);
        set_in(1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 1'b1, 64'd2);
        tick(); check("stats_b4", PC, 64'd20);
        set_in(1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 64'd1);
        tick();
        check("stats_b5_pc",   PC, 64'd20);
        check("stats_b5_trap", {63'd0, Trap}, 64'd1);
`ifdef PC_BRANCH_STATS_EN
        check("stats_bcount", {32'd0, BranchCount}, 64'd5);
        check("stats_tcount", {32'd0, TakenCount},  64'd2);
`endif
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
